// File: rtl/hazard_controller.sv
// Hazard control for the five-stage core: operand forwarding selects, load-use/branch/MUL-DIV stall and flush, stall-cycle counter.
// Forwarding, stall and flush outputs are combinational from this cycle's inputs; MulDivBusy and StallCount are registered; no handshake.
module hazard_controller #(
    parameter int MULDIV_LATENCY = 4,
    parameter int CNT_W          = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        ResultSrcE0,
    input  logic        PCSrcE,
    input  logic        MulDivStartE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        MulDivBusy,
    output logic [31:0] StallCount
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULDIV_LATENCY - 2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_md_stall;
    logic             w_lw_stall;
    logic             w_stall_fd;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic [31:0]      r_stall_count;

    // M stage wins over W; x0 is hard-wired zero and must never forward.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wm, input logic [4:0] rdm,
                                           input logic ww, input logic [4:0] rdw);
        if (wm && (rdm != 5'd0) && (rdm == rs))
            return 2'b10;
        else if (ww && (rdw != 5'd0) && (rdw == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_fwd_a    = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    assign w_fwd_b    = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    assign w_lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign w_stall_fd = (w_lw_stall && !PCSrcE) || w_md_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Start is only sampled in IDLE so the held instruction cannot retrigger.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_md_stall  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MulDivStartE) begin
                    w_md_stall  = 1'b1;
                    w_cnt_nxt   = CNT_INIT;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt != '0) begin
                    w_md_stall = 1'b1;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_count <= 32'd0;
        else if (StallF)
            r_stall_count <= r_stall_count + 32'd1;
    end

    assign ForwardAE  = rst ? w_fwd_a : 2'b00;
    assign ForwardBE  = rst ? w_fwd_b : 2'b00;
    assign StallF     = rst && w_stall_fd;
    assign StallD     = rst && w_stall_fd;
    assign StallE     = rst && w_md_stall;
    assign FlushM     = rst && w_md_stall;
    assign FlushD     = rst && PCSrcE;
    assign FlushE     = rst && (w_lw_stall || PCSrcE);
    assign MulDivBusy = (r_state == S_BUSY);
    assign StallCount = r_stall_count;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios, then random traffic against a behavioural model.
module tb_hazard_controller;
    localparam int L = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulDivStartE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDivBusy;
    logic [31:0] StallCount;

    hazard_controller #(.MULDIV_LATENCY(L), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
        .PCSrcE(PCSrcE), .MulDivStartE(MulDivStartE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .MulDivBusy(MulDivBusy), .StallCount(StallCount)
    );

    int          n_vec = 0;
    int          n_err = 0;
    // Model: m_pos = -1 when no MUL/DIV is in Execute, else its cycle index 0..L-1.
    int          m_pos;
    int          pos_now;
    logic [31:0] m_cnt;
    logic        e_stall;
    logic [31:0] base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0; MulDivStartE = 0;
    endtask

    task automatic settle();
        logic lw, md;
        #1;
        lw      = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        pos_now = (m_pos < 0 && MulDivStartE) ? 0 : m_pos;
        md      = (pos_now >= 0) && (pos_now < L - 1);
        e_stall = (lw && !PCSrcE) || md;
        chk("ForwardAE",  ForwardAE,  ref_fwd(Rs1E));
        chk("ForwardBE",  ForwardBE,  ref_fwd(Rs2E));
        chk("StallF",     StallF,     e_stall);
        chk("StallD",     StallD,     e_stall);
        chk("StallE",     StallE,     md);
        chk("FlushM",     FlushM,     md);
        chk("FlushD",     FlushD,     PCSrcE);
        chk("FlushE",     FlushE,     lw || PCSrcE);
        chk("MulDivBusy", MulDivBusy, m_pos >= 1);
        chk("StallCount", StallCount, m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        if (e_stall) m_cnt = m_cnt + 32'd1;
        if (pos_now >= 0) begin
            m_pos = pos_now + 1;
            if (m_pos == L) m_pos = -1;
        end else begin
            m_pos = -1;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fwdA"}, ForwardAE, 2'b00);
        chk({tag, "_fwdB"}, ForwardBE, 2'b00);
        chk({tag, "_stall"}, {StallF, StallD, StallE}, 3'b000);
        chk({tag, "_flush"}, {FlushD, FlushE, FlushM}, 3'b000);
        chk({tag, "_busy"}, MulDivBusy, 1'b0);
        chk({tag, "_cnt"}, StallCount, 32'd0);
    endtask

    initial begin
        idle_inputs();
        m_pos = -1;
        m_cnt = 32'd0;
        rst   = 1'b1;
        #2 rst = 1'b0;
        // Hazards present on the inputs must not leak out during reset.
        Rs1E = 5; RdM = 5; RegWriteM = 1; Rs2E = 6; RdW = 6; RegWriteW = 1;
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7; PCSrcE = 1; MulDivStartE = 1;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;

        // Forwarding priority
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        settle(); chk("fwd_M_prio", ForwardAE, 2'b10); tick();
        RegWriteM = 0;
        settle(); chk("fwd_W", ForwardAE, 2'b01); tick();
        RdM = 0; RdW = 0; RegWriteM = 1; RegWriteW = 1; Rs1E = 0;
        settle(); chk("fwd_x0", ForwardAE, 2'b00); tick();
        idle_inputs(); Rs2E = 9; RdW = 9; RegWriteW = 1; RdM = 8; RegWriteM = 1;
        settle(); chk("fwdB_W", ForwardBE, 2'b01); tick();

        // Load-use
        idle_inputs(); base = m_cnt;
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        settle(); chk("lu_stall", {StallF, StallD, FlushE}, 3'b111); tick();
        idle_inputs();
        settle(); chk("lu_release", StallF, 1'b0); chk("lu_count", StallCount, base + 32'd1); tick();
        ResultSrcE0 = 1; RdE = 0; Rs1D = 0; Rs2D = 0;
        settle(); chk("lu_x0", {StallF, FlushE}, 2'b00); tick();

        // Back-to-back MUL/DIV, start held throughout
        idle_inputs(); base = m_cnt; MulDivStartE = 1;
        for (int i = 0; i < 2 * L; i++) begin
            settle();
            chk("md_stall", {StallF, StallD, StallE, FlushM}, ((i % L) < L - 1) ? 4'hF : 4'h0);
            chk("md_busy", MulDivBusy, (i % L) >= 1);
            tick();
        end
        MulDivStartE = 0;
        settle(); chk("md_count", StallCount, base + 32'd6); chk("md_idle", MulDivBusy, 1'b0); tick();

        // Branch overrides load-use
        ResultSrcE0 = 1; RdE = 3; Rs1D = 3; PCSrcE = 1;
        settle(); chk("br_lu", {StallF, StallD, FlushD, FlushE}, 4'b0011); tick();

        // Reset in cycle 1 of a MUL/DIV
        idle_inputs(); MulDivStartE = 1;
        settle(); tick();
        settle();
        rst = 1'b0;
        #1 check_reset_outputs("rst_busy");
        m_pos = -1; m_cnt = 32'd0;
        @(negedge clk);
        MulDivStartE = 0; rst = 1'b1;
        settle(); chk("rst_rel", {StallF, MulDivBusy}, 2'b00); tick();

        // Counter wrap
        idle_inputs();
        force dut.r_stall_count = 32'hFFFF_FFFF;
        #1 release dut.r_stall_count;
        m_cnt = 32'hFFFF_FFFF;
        ResultSrcE0 = 1; RdE = 4; Rs1D = 4;
        settle(); tick();
        idle_inputs();
        settle(); chk("wrap", StallCount, 32'd0); tick();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
            Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
            RdE  = 5'($urandom_range(0, 7)); RdM  = 5'($urandom_range(0, 7));
            RdW  = 5'($urandom_range(0, 7));
            RegWriteM    = ($urandom_range(0, 1) == 0);
            RegWriteW    = ($urandom_range(0, 1) == 0);
            ResultSrcE0  = ($urandom_range(0, 2) == 0);
            PCSrcE       = ($urandom_range(0, 5) == 0);
            MulDivStartE = ($urandom_range(0, 7) == 0);
            settle();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
